riscvsys_evcnt: RTL and testbench



---
 rtl/riscvsys_evcnt_pkg.sv | 19 +
 rtl/riscvsys_evcnt_ctr.sv | 33 +++
 rtl/riscvsys_evcnt.sv | 85 ++++++++
 tb/tb_riscvsys_evcnt.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscvsys_evcnt_pkg.sv
// riscvsys_evcnt_pkg: shared constants and event indices for the event-counter bank
package riscvsys_evcnt_pkg;
    localparam int N_EV_DEFAULT = 49;
    localparam logic [11:0] OFS_CTRL   = 12'h000;
    localparam logic [11:0] OFS_SNAP   = 12'h004;
    localparam logic [11:0] OFS_OVF    = 12'h008;
    localparam logic [11:0] OFS_LIVE   = 12'h100;
    localparam logic [11:0] OFS_SHADOW = 12'h400;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_FRZ = 1;
    localparam int CTRL_CLR = 2;
    typedef enum logic [5:0] {
        EV_LUI, EV_AUIPC, EV_JAL, EV_JALR, EV_BEQ, EV_BNE, EV_BLT, EV_BGE, EV_BLTU, EV_BGEU,
        EV_LB, EV_LH, EV_LW, EV_LBU, EV_LHU, EV_SB, EV_SH, EV_SW, EV_ADDI, EV_SLTI,
        EV_SLTIU, EV_XORI, EV_ORI, EV_ANDI, EV_SLLI, EV_SRLI, EV_SRAI, EV_ADD, EV_SUB, EV_SLL,
        EV_SLT, EV_SLTU, EV_XOR, EV_SRL, EV_SRA, EV_OR, EV_AND, EV_RDCYCLE, EV_RDCYCLEH, EV_RDINSTR,
        EV_RDINSTRH, EV_ECALL_EBREAK, EV_GETQ, EV_SETQ, EV_RETIRQ, EV_MASKIRQ, EV_WAITIRQ, EV_TIMER, EV_TRAP
    } ev_e;
endpackage

// File: rtl/riscvsys_evcnt_ctr.sv
// riscvsys_evcnt_ctr: one saturating event counter with its snapshot shadow
module riscvsys_evcnt_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] shadow,
    output logic             sat
);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [CNT_W-1:0] count_q, count_d, shadow_q, shadow_d;
    always_comb begin
        count_d  = clr ? '0 : (inc && count_q != MAX) ? count_q + CNT_W'(1) : count_q;
        shadow_d = clr ? '0 : snap ? count_q : shadow_q;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end
    assign count  = count_q;
    assign shadow = shadow_q;
    // flags the increment that lands on (or is blocked at) all-ones
    assign sat    = inc & ((count_q | CNT_W'(1)) == MAX);
endmodule

// File: rtl/riscvsys_evcnt.sv
// riscvsys_evcnt: memory-mapped bank of saturating per-instruction event counters
module riscvsys_evcnt
    import riscvsys_evcnt_pkg::*;
#(
    parameter int          N_EV      = N_EV_DEFAULT,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [N_EV-1:0] i_ev,
    input  logic            i_mem_valid,
    input  logic [31:0]     i_mem_addr,
    input  logic [31:0]     i_mem_wdata,
    input  logic [3:0]      i_mem_wstrb,
    output logic            o_sel,
    output logic            o_mem_ready,
    output logic [31:0]     o_mem_rdata
);
    localparam int IW = N_EV > 1 ? $clog2(N_EV) : 1;
    localparam logic [11:0] SPAN = 12'(4 * N_EV);
    logic [CNT_W-1:0] count [N_EV];
    logic [CNT_W-1:0] shadow [N_EV];
    logic [N_EV-1:0]  sat;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             ovf_q, ovf_d, ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d, rd;
    logic [11:0]      ofs, live_ofs, shd_ofs;
    logic             acc, wr, clr, snap, cnt_en, live_hit, shd_hit, unused_wdata;

    assign o_sel        = i_mem_addr[31:12] == BASE_ADDR[31:12];
    assign ofs          = i_mem_addr[11:0];
    assign acc          = i_mem_valid & o_sel & ~ready_q;
    assign wr           = acc & (|i_mem_wstrb);
    assign clr          = wr & (ofs == OFS_CTRL) & i_mem_wdata[CTRL_CLR];
    assign snap         = wr & (ofs == OFS_SNAP);
    assign cnt_en       = ctrl_q[CTRL_EN] & ~ctrl_q[CTRL_FRZ];
    // offsets below a region wrap to large values and fail the span test
    assign live_ofs     = ofs - OFS_LIVE;
    assign shd_ofs      = ofs - OFS_SHADOW;
    assign live_hit     = live_ofs < SPAN && live_ofs[1:0] == 2'b00;
    assign shd_hit      = shd_ofs < SPAN && shd_ofs[1:0] == 2'b00;
    assign unused_wdata = ^i_mem_wdata[31:3];

    for (genvar i = 0; i < N_EV; i++) begin : g_ctr
        riscvsys_evcnt_ctr #(.CNT_W(CNT_W)) u_ctr (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .inc    (i_ev[i] & cnt_en),
            .clr    (clr),
            .snap   (snap),
            .count  (count[i]),
            .shadow (shadow[i]),
            .sat    (sat[i])
        );
    end

    always_comb begin
        rd      = (ofs == OFS_CTRL) ? {30'd0, ctrl_q} :
                  (ofs == OFS_OVF)  ? {31'd0, ovf_q} :
                  live_hit          ? 32'(count[live_ofs[IW+1:2]]) :
                  shd_hit           ? 32'(shadow[shd_ofs[IW+1:2]]) : '0;
        ctrl_d  = (wr && ofs == OFS_CTRL) ? i_mem_wdata[1:0] : ctrl_q;
        ovf_d   = ~clr & (ovf_q | (|sat));
        ready_d = acc;
        rdata_d = acc ? rd : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctrl_q  <= 2'b01;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_mem_ready = ready_q;
    assign o_mem_rdata = rdata_q;
endmodule

// File: tb/tb_riscvsys_evcnt.sv
// tb_riscvsys_evcnt: directed and random checks of 32-bit and 4-bit counter banks against a count model
module tb_riscvsys_evcnt;
    localparam int N = 49;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [N-1:0] ev = '0;
    logic valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic sel_a, sel_b, rdy_a, rdy_b;
    logic [31:0] rd_a, rd_b;
    logic [31:0] ra, rb;

    longint cnt [N];
    longint shd [N];
    bit en, frz;
    int checks = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscvsys_evcnt u_a (
        .i_clk(clk), .i_rstn(rstn), .i_ev(ev), .i_mem_valid(valid), .i_mem_addr(addr),
        .i_mem_wdata(wdata), .i_mem_wstrb(wstrb), .o_sel(sel_a), .o_mem_ready(rdy_a), .o_mem_rdata(rd_a)
    );
    riscvsys_evcnt #(.CNT_W(4)) u_b (
        .i_clk(clk), .i_rstn(rstn), .i_ev(ev), .i_mem_valid(valid), .i_mem_addr(addr),
        .i_mem_wdata(wdata), .i_mem_wstrb(wstrb), .o_sel(sel_b), .o_mem_ready(rdy_b), .o_mem_rdata(rd_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (cnt[i]) begin
            cnt[i] = 0;
            shd[i] = 0;
        end
        en  = 1'b1;
        frz = 1'b0;
    endtask

    function automatic longint cap(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return v > m ? m : v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [11:0] o, input int w);
        int io;
        io = int'(o);
        if (io == 'h000) return {30'd0, frz, en};
        if (io == 'h008) begin
            foreach (cnt[i]) if (cap(cnt[i], w) == cap(64'h7fff_ffff_ffff, w)) return 32'd1;
            return 32'd0;
        end
        if (io % 4 == 0 && io >= 'h100 && io < 'h100 + 4 * N) return 32'(cap(cnt[(io - 'h100) / 4], w));
        if (io % 4 == 0 && io >= 'h400 && io < 'h400 + 4 * N) return 32'(cap(shd[(io - 'h400) / 4], w));
        return 32'd0;
    endfunction

    // one clock edge of the programmer-visible behaviour
    task automatic model_edge(input logic [N-1:0] e, input bit wr, input logic [11:0] o, input logic [31:0] d);
        if (wr && o == 12'h004) foreach (shd[i]) shd[i] = cnt[i];
        if (en && !frz) foreach (cnt[i]) if (e[i]) cnt[i]++;
        if (wr && o == 12'h000) begin
            en  = d[0];
            frz = d[1];
            if (d[2]) foreach (cnt[i]) begin
                cnt[i] = 0;
                shd[i] = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] rnd_ev();
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) e[i] = ($urandom_range(0, 7) == 0);
        return e;
    endfunction

    task automatic idle(input logic [N-1:0] e);
        ev = e;
        @(posedge clk);
        model_edge(e, 1'b0, 12'h000, 32'd0);
        @(negedge clk);
        ev = '0;
    endtask

    task automatic pulse(input int b, input int n);
        logic [N-1:0] e;
        e = '0;
        e[b] = 1'b1;
        repeat (n) idle(e);
    endtask

    task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] d, input logic [N-1:0] e,
                          input string tag, output logic [31:0] oa, output logic [31:0] ob);
        bit hit;
        logic [31:0] ea, eb;
        hit = (a[31:12] == BASE[31:12]);
        ea = exp_rd(a[11:0], 32);
        eb = exp_rd(a[11:0], 4);
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = wr ? 4'($urandom_range(1, 15)) : 4'd0;
        ev    = e;
        #1 check({tag, " sel"}, {30'd0, sel_b, sel_a}, {30'd0, hit, hit});
        @(posedge clk);
        model_edge(e, wr && hit, a[11:0], d);
        @(negedge clk);
        ev = '0;
        check({tag, " ack"}, {30'd0, rdy_b, rdy_a}, {30'd0, hit, hit});
        if (hit && !wr) begin
            check({tag, " rdata32"}, rd_a, ea);
            check({tag, " rdata4"}, rd_b, eb);
        end
        oa = rd_a;
        ob = rd_b;
        @(negedge clk);
        check({tag, " ack once"}, {30'd0, rdy_b, rdy_a}, 32'd0);
        valid = 1'b0;
        wstrb = '0;
    endtask

    initial begin
        logic [N-1:0] e;
        logic [11:0] o;
        int k;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset ready", {30'd0, rdy_b, rdy_a}, 32'd0);
        check("reset rdata", rd_a | rd_b, 32'd0);
        rstn = 1'b1;

        access(BASE, 1'b0, 32'd0, '0, "ctrl reset", ra, rb);
        check("ctrl reset value", ra, 32'h1);
        access(BASE + 32'h8, 1'b0, 32'd0, '0, "ovf reset", ra, rb);
        check("ovf reset value", ra, 32'h0);
        access(BASE + 32'h100, 1'b0, 32'd0, '0, "live0 reset", ra, rb);
        check("live0 reset value", ra, 32'h0);

        pulse(18, 5);
        access(BASE + 32'h148, 1'b0, 32'd0, '0, "addi", ra, rb);
        check("addi count", ra, 32'd5);
        access(BASE + 32'h14C, 1'b0, 32'd0, '0, "slti", ra, rb);
        check("slti count", ra, 32'd0);

        pulse(0, 3);
        access(BASE + 32'h4, 1'b1, 32'd1, '0, "snap wr", ra, rb);
        pulse(0, 2);
        access(BASE + 32'h100, 1'b0, 32'd0, '0, "lui live", ra, rb);
        check("lui live value", ra, 32'd5);
        access(BASE + 32'h400, 1'b0, 32'd0, '0, "lui shadow", ra, rb);
        check("lui shadow value", ra, 32'd3);

        access(BASE, 1'b1, 32'h5, '0, "clr wr", ra, rb);
        access(BASE + 32'h100, 1'b0, 32'd0, '0, "live after clr", ra, rb);
        check("live after clr value", ra, 32'd0);
        access(BASE + 32'h400, 1'b0, 32'd0, '0, "shadow after clr", ra, rb);
        check("shadow after clr value", ra, 32'd0);
        access(BASE, 1'b0, 32'd0, '0, "ctrl after clr", ra, rb);
        check("ctrl after clr value", ra, 32'h1);

        pulse(1, 20);
        access(BASE + 32'h104, 1'b0, 32'd0, '0, "auipc", ra, rb);
        check("auipc 32b", ra, 32'd20);
        check("auipc 4b sat", rb, 32'hF);
        access(BASE + 32'h8, 1'b0, 32'd0, '0, "ovf", ra, rb);
        check("ovf 32b", ra, 32'd0);
        check("ovf 4b", rb, 32'd1);
        pulse(1, 1);
        access(BASE + 32'h104, 1'b0, 32'd0, '0, "auipc again", ra, rb);
        check("auipc 4b held", rb, 32'hF);
        check("auipc 32b more", ra, 32'd21);

        e = '0;
        e[2] = 1'b1;
        access(BASE, 1'b1, 32'h3, e, "frz wr", ra, rb);
        access(BASE + 32'h108, 1'b0, 32'd0, '0, "jal frz", ra, rb);
        check("jal counted at frz write", ra, 32'd1);
        pulse(2, 4);
        access(BASE + 32'h108, 1'b0, 32'd0, '0, "jal frozen", ra, rb);
        check("jal frozen value", ra, 32'd1);
        access(BASE, 1'b1, 32'h1, '0, "unfrz wr", ra, rb);
        pulse(2, 1);
        access(BASE + 32'h108, 1'b0, 32'd0, '0, "jal thawed", ra, rb);
        check("jal thawed value", ra, 32'd2);

        // reset lands between the edges of a pending ack
        valid = 1'b1;
        addr  = BASE;
        wstrb = '0;
        @(posedge clk);
        @(negedge clk);
        check("ack before reset", {30'd0, rdy_b, rdy_a}, 32'h3);
        #2 rstn = 1'b0;
        #1 check("async reset drops ack", {30'd0, rdy_b, rdy_a}, 32'd0);
        valid = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        access(BASE + 32'h1C4, 1'b0, 32'd0, '0, "out of range", ra, rb);
        check("out of range value", ra | rb, 32'd0);
        access(32'h2000_0000, 1'b1, 32'h2, '0, "foreign addr", ra, rb);
        access(BASE, 1'b0, 32'd0, '0, "ctrl untouched", ra, rb);
        check("ctrl untouched value", ra, 32'h1);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4) idle(rnd_ev());
            else if (k < 8) begin
                k = $urandom_range(0, 3);
                o = (k == 0) ? 12'(12'h100 + 4 * $urandom_range(0, N)) :
                    (k == 1) ? 12'(12'h400 + 4 * $urandom_range(0, N)) :
                    (k == 2) ? 12'h000 : 12'h008;
                access(BASE | 32'(o), 1'b0, 32'd0, rnd_ev(), "rnd read", ra, rb);
            end else if (k == 8) access(BASE + 32'h4, 1'b1, $urandom, rnd_ev(), "rnd snap", ra, rb);
            else access(BASE, 1'b1, {29'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 4) != 0}, rnd_ev(), "rnd ctrl", ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
